// File: rtl/stream_width_downsizer_pkg.sv
// Shared definitions for the stream width downsizer: FSM state encoding and
// the index-width helper used to size the beat counter.
package stream_width_downsizer_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // A beat index for RATIO=1 still needs one bit to be a legal vector.
  function automatic int clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/stream_width_downsizer.sv
// Splits one IN_WIDTH word per input handshake into RATIO registered OUT_WIDTH
// beats (LS slice first) and marks packet ends from a programmable beat count.
module stream_width_downsizer
  import stream_width_downsizer_pkg::*;
#(
  parameter int OUT_WIDTH     = 16,
  parameter int RATIO         = 4,
  parameter int PKT_LEN_WIDTH = 16,
  localparam int IN_WIDTH     = OUT_WIDTH * RATIO
) (
  input  logic                     aclk,
  input  logic                     reset,
  input  logic [PKT_LEN_WIDTH-1:0] cfg_packet_beats,
  input  logic                     s_stream_tvalid,
  input  logic [IN_WIDTH-1:0]      s_stream_tdata,
  output logic                     s_stream_tready,
  output logic                     m_stream_tvalid,
  output logic [OUT_WIDTH-1:0]     m_stream_tdata,
  output logic                     m_stream_tlast,
  input  logic                     m_stream_tready,
  output state_e                   o_dbg_state
);

  localparam int IDX_W = clog2(RATIO);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [PKT_LEN_WIDTH-1:0] PKT_ONE  = PKT_LEN_WIDTH'(1);

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // tvalid and tready are both high; valid never waits on ready.
  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [IN_WIDTH-1:0]      r_shreg;
  logic [IDX_W-1:0]         r_idx;
  logic [PKT_LEN_WIDTH-1:0] r_pcnt;
  logic [PKT_LEN_WIDTH-1:0] w_pcnt_nxt;
  logic                     r_tlast;
  logic                     w_tlast_nxt;
  logic                     w_in_hs;
  logic                     w_out_hs;
  logic                     w_last_idx;
  logic                     w_cfg_en;
  logic                     w_pkt_end;

  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_in_hs    = s_stream_tvalid && s_stream_tready;
  assign w_out_hs   = m_stream_tvalid && m_stream_tready;
  assign w_cfg_en   = (cfg_packet_beats != '0);
  assign w_pkt_end  = w_cfg_en && (r_pcnt == cfg_packet_beats - PKT_ONE);

  // Combinational from m_stream_tready so the last beat and the next load overlap.
  assign s_stream_tready = !reset &&
                           ((r_state == ST_EMPTY) || (m_stream_tready && w_last_idx));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_in_hs) w_state_nxt = ST_FULL;
      ST_FULL:  if (w_out_hs && w_last_idx && !w_in_hs) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // tlast is precomputed for the beat that will be on the port after the edge.
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (!w_cfg_en) begin
      w_pcnt_nxt = '0;
    end else if (w_out_hs) begin
      w_pcnt_nxt = w_pkt_end ? '0 : r_pcnt + PKT_ONE;
    end
    w_tlast_nxt = (w_state_nxt == ST_FULL) && w_cfg_en &&
                  (w_pcnt_nxt == cfg_packet_beats - PKT_ONE);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_shreg <= '0;
      r_idx   <= '0;
      r_pcnt  <= '0;
      r_tlast <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_tlast <= w_tlast_nxt;
      if (w_in_hs) begin
        r_shreg <= s_stream_tdata;
        r_idx   <= '0;
      end else if (w_out_hs) begin
        if (w_last_idx) begin
          r_idx <= '0;
        end else begin
          r_shreg <= r_shreg >> OUT_WIDTH;
          r_idx   <= r_idx + 1'b1;
        end
      end
    end
  end

  assign m_stream_tvalid = (r_state == ST_FULL);
  assign m_stream_tdata  = r_shreg[OUT_WIDTH-1:0];
  assign m_stream_tlast  = r_tlast;
  assign o_dbg_state     = r_state;

endmodule

// File: doc/stream_width_downsizer.md
# stream_width_downsizer

Downstream stage of the four-lane stream concatenator. It accepts one wide concatenated word per handshake and emits it as `RATIO` narrower beats, least-significant slice first, on a registered AXI-Stream-style master port. It also generates `m_stream_tlast` from a programmable packet length. The registered outputs break the unregistered valid/data path coming out of the concatenator before the memory or display interface.

## Interface
Parameters:
- `OUT_WIDTH`, default 16: width of one output beat.
- `RATIO`, default 4: output beats per input word, must be ≥1; `IN_WIDTH = OUT_WIDTH*RATIO` is a localparam.
- `PKT_LEN_WIDTH`, default 16: width of the packet-length input.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_packet_beats`  in  `PKT_LEN_WIDTH`  output beats per packet; 0 disables `tlast`.
- `s_stream_tvalid`  in  1  input word valid.
- `s_stream_tdata`  in  `IN_WIDTH`  concatenated input word.
- `s_stream_tready`  out  1  input word accepted when high together with `s_stream_tvalid`.
- `m_stream_tvalid`  out  1  output beat valid (registered).
- `m_stream_tdata`  out  `OUT_WIDTH`  output beat (registered).
- `m_stream_tlast`  out  1  last beat of packet (registered).
- `m_stream_tready`  in  1  downstream ready.

## Operation
- Storage is a single `IN_WIDTH` shift register plus beat index `idx` (0..`RATIO`-1).
- The state machine has two states:
  - **EMPTY:** no word held. `m_stream_tvalid`=0.
  - **FULL:** word held. `m_stream_tvalid`=1, `m_stream_tdata` = `shreg[OUT_WIDTH-1:0]`.
- `s_stream_tready` = !reset && (EMPTY || (`m_stream_tready` && `idx`==`RATIO`-1)).
  - This is a combinational path from `m_stream_tready`. It is intended, because the upstream block's output is not registered either.
- EMPTY, input handshake → FULL. Load `shreg` with `s_stream_tdata`, set `idx`=0.
- FULL, output handshake, `idx`<`RATIO`-1 → shift `shreg` right by `OUT_WIDTH`, `idx`+1.
- FULL, output handshake, `idx`==`RATIO`-1:
  - With a simultaneous input handshake: reload `shreg` and set `idx`=0, staying in FULL with no bubble.
  - Otherwise: go to EMPTY.
- FULL without an output handshake: all state holds. Data and `tlast` are stable while valid and not ready.
- Packet counter `pcnt` (`PKT_LEN_WIDTH` bits) counts accepted output beats.
  - `tlast` = (`cfg_packet_beats`≠0) && (`pcnt`==`cfg_packet_beats`-1).
  - On a handshake with `tlast`, `pcnt` wraps to 0; otherwise it increments.
  - `cfg_packet_beats` must be held stable between packets; changing it mid-packet is undefined.
  - With `cfg_packet_beats`=0, `pcnt` stays 0 and `tlast` stays 0.
- Packets need not align to input words: `tlast` may fall on any `idx`.
- `RATIO`=1: behaves as a one-entry registered pipeline stage, `s_stream_tready` = EMPTY || `m_stream_tready`.

## Timing
- Reset values: `m_stream_tvalid`=0, `m_stream_tdata`=0, `m_stream_tlast`=0, state EMPTY, `idx`=0, `pcnt`=0.
- `s_stream_tready`=0 while `reset` is high.
- Reset asserted mid-word discards the held word and the partial packet count.
- Latency: a word accepted at edge k has beat 0 valid after edge k; beat j is presented no earlier than after edge k+j.
- Throughput: 1 output beat/cycle sustained when upstream supplies 1 word per `RATIO` cycles and downstream is always ready.
- Input acceptance is at most one word per `RATIO` cycles.
- `m_stream_tlast` is computed from registered `pcnt` and the stable config, and is registered alongside `tdata`.

## Structure
- Single module, no sub-module.
- Shared package: no typedefs are required. The `clog2` helper used for the `idx` width belongs in the common stream package; guard `RATIO`=1 to a 1-bit `idx`.
- Shift register and counters sit in one clocked process; the ready equation is in one continuous assignment.

## Test plan
- Reset check: `OUT_WIDTH`=16, `RATIO`=4; send `0x4444_3333_2222_1111` with `m_stream_tready`=1 → beats `1111`, `2222`, `3333`, `4444` on 4 consecutive cycles; `s_stream_tready` is high only in the 4th cycle.
- Back-to-back: two words supplied continuously, ready always high → 8 contiguous beats, no bubble between words.
- Backpressure: drop `m_stream_tready` for 3 cycles during beat 2 → `tdata`=`3333` and `tvalid` are held stable, `s_stream_tready`=0, no beat lost or duplicated.
- Packets: `cfg_packet_beats`=6, three words → `tlast` on the 6th and 12th beats (idx 1 and idx 3); `cfg_packet_beats`=0 → `tlast` never asserted.
- Reset mid-word: assert `reset` after beat 1, then send `0xDDDD_CCCC_BBBB_AAAA` → outputs return to 0 after one edge; the next beats are `AAAA`…`DDDD` with `pcnt` restarted at 0.
- `RATIO`=1: random valid/ready over 1000 cycles → output sequence equals input sequence, and no more than 1 word is ever outstanding.
